// File: rtl/systolic_conv_pkg.sv
// systolic_conv_pkg
//   Shared types and helpers for the systolic convolution engine.
//   - state_t   : FSM encoding (IDLE, COMPUTE, STREAM, FIN)
//   - out_n_fn  : output side length of a valid-mode convolution
//   - idx_w_fn  : index width for a count, never below 1 bit
//   - sat_fn    : clamp a signed value into an out_w-bit signed range
//   - relu_fn   : clip negatives to zero
package systolic_conv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        STREAM  = 2'd2,
        FIN     = 2'd3
    } state_t;

    function automatic int out_n_fn(input int img_n, input int ker_k);
        return img_n - ker_k + 1;
    endfunction

    function automatic int idx_w_fn(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [63:0] sat_fn(input logic signed [63:0] acc,
                                                  input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
    endfunction

    function automatic logic signed [63:0] relu_fn(input logic signed [63:0] v);
        return (v < 0) ? 64'sd0 : v;
    endfunction

endpackage

// File: rtl/systolic_conv_pe.sv
// systolic_conv_pe
//   Signed multiply-accumulate processing element.
//   Ports:
//     clk, rst   : clock, synchronous active-low reset
//     clear      : zero the accumulator (start of a new job)
//     en         : accumulate pix*coef this cycle
//     pix, coef  : signed DATA_W operands
//     acc        : signed ACC_W running sum
module systolic_conv_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] pix,
    input  logic signed [DATA_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = pix * coef;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            // size cast of a signed product sign-extends into the accumulator
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/systolic_conv_engine.sv
// systolic_conv_engine
//   Valid-mode 2-D convolution of an IMG_N x IMG_N image with a KER_K x KER_K
//   filter on an OUT_N x OUT_N grid of MAC PEs, streamed out row-major.
//   Optional build macro SYSTOLIC_CONV_RELU_EN: negative saturated results
//   are output as 0.
//   Ports:
//     clk, rst        : clock, synchronous active-low reset
//     start           : job request, only honoured in IDLE
//     img_flat        : image, row-major, element (0,0) in LSBs
//     fil_flat        : filter, row-major, element (0,0) in LSBs
//     busy            : not IDLE
//     out_valid/ready : result handshake; a result transfers on valid & ready.
//                       While valid is high and ready is low, data/row/col
//                       are held stable.
//     out_data        : saturated result
//     out_row/out_col : position of the presented result
//     done            : one-cycle pulse after the last result transfers
//     fsm_state       : current FSM state (debug)
module systolic_conv_engine
    import systolic_conv_pkg::*;
#(
    parameter int IMG_N  = 4,
    parameter int KER_K  = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(KER_K*KER_K),
    parameter int OUT_W  = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [IMG_N*IMG_N*DATA_W-1:0]                  img_flat,
    input  logic [KER_K*KER_K*DATA_W-1:0]                  fil_flat,
    output logic                                           busy,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic signed [OUT_W-1:0]                        out_data,
    output logic [idx_w_fn(out_n_fn(IMG_N, KER_K))-1:0]    out_row,
    output logic [idx_w_fn(out_n_fn(IMG_N, KER_K))-1:0]    out_col,
    output logic                                           done,
    output state_t                                         fsm_state
);

    localparam int OUT_N = out_n_fn(IMG_N, KER_K);
    localparam int IDX_W = idx_w_fn(OUT_N);
    localparam int TAPS  = KER_K * KER_K;
    localparam int TAP_W = idx_w_fn(TAPS);
    localparam int NPE   = OUT_N * OUT_N;
    localparam int SEL_W = idx_w_fn(NPE);

    state_t state, state_nxt;

    logic [IMG_N*IMG_N*DATA_W-1:0] img_q;
    logic [TAPS*DATA_W-1:0]        fil_q;
    logic [TAP_W-1:0]              tap;
    logic [IDX_W-1:0]              row_q, col_q;
    logic [SEL_W-1:0]              sel_q;
    logic                          accept, last_tap, last_out, pe_clear, pe_en;
    logic signed [DATA_W-1:0]      coef;
    logic signed [ACC_W-1:0]       acc_arr [NPE];
    logic signed [ACC_W-1:0]       acc_sel;

    assign accept    = (state == STREAM) && out_ready;
    assign last_tap  = (tap == TAP_W'(TAPS - 1));
    assign last_out  = (row_q == IDX_W'(OUT_N - 1)) && (col_q == IDX_W'(OUT_N - 1));
    assign pe_clear  = (state == IDLE) && start;
    assign pe_en     = (state == COMPUTE);
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                if (last_tap) state_nxt = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                if (accept && last_out) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latches, tap counter and output index. Row/col return to 0
    // after the last transfer so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            img_q <= '0;
            fil_q <= '0;
            tap   <= '0;
            row_q <= '0;
            col_q <= '0;
            sel_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        img_q <= img_flat;
                        fil_q <= fil_flat;
                        tap   <= '0;
                    end
                end
                COMPUTE: begin
                    tap <= last_tap ? '0 : tap + 1'b1;
                end
                STREAM: begin
                    if (accept) begin
                        if (last_out) begin
                            row_q <= '0;
                            col_q <= '0;
                            sel_q <= '0;
                        end else begin
                            sel_q <= sel_q + 1'b1;
                            if (col_q == IDX_W'(OUT_N - 1)) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Filter tap broadcast to every PE: fil[r][c] with tap = r*KER_K + c.
    always_comb begin
        coef = '0;
        for (int t = 0; t < TAPS; t++) begin
            if (tap == TAP_W'(t)) coef = fil_q[t*DATA_W +: DATA_W];
        end
    end

    for (genvar i = 0; i < OUT_N; i++) begin : g_row
        for (genvar j = 0; j < OUT_N; j++) begin : g_col
            logic signed [DATA_W-1:0] pix;

            // PE(i,j) sees img[i+r][j+c] during tap (r,c).
            always_comb begin
                pix = '0;
                for (int r = 0; r < KER_K; r++) begin
                    for (int c = 0; c < KER_K; c++) begin
                        if (tap == TAP_W'(r*KER_K + c))
                            pix = img_q[((i+r)*IMG_N + j + c)*DATA_W +: DATA_W];
                    end
                end
            end

            systolic_conv_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clear (pe_clear),
                .en    (pe_en),
                .pix   (pix),
                .coef  (coef),
                .acc   (acc_arr[i*OUT_N + j])
            );
        end
    end

    always_comb begin
        acc_sel = '0;
        for (int k = 0; k < NPE; k++) begin
            if (sel_q == SEL_W'(k)) acc_sel = acc_arr[k];
        end
    end

    // Saturation first, then the optional ReLU; zero outside STREAM.
    always_comb begin
        out_data = '0;
        if (state == STREAM) begin
`ifdef SYSTOLIC_CONV_RELU_EN
            out_data = OUT_W'(relu_fn(sat_fn(64'(acc_sel), OUT_W)));
`else
            out_data = OUT_W'(sat_fn(64'(acc_sel), OUT_W));
`endif
        end
    end

endmodule

// File: tb/tb_systolic_conv_engine.sv
// tb_systolic_conv_engine
//   Directed bench for systolic_conv_engine: a default 4/3 instance and a
//   5/3 instance. Expected results are hand-computed and queued in exp_q.
module tb_systolic_conv_engine;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 4x4 / 3x3 ----------------
    logic               start, busy, out_valid, out_ready, done;
    logic [127:0]       img_flat;
    logic [71:0]        fil_flat;
    logic signed [7:0]  out_data;
    logic [0:0]         out_row, out_col;
    logic [1:0]         fsm_state;

    systolic_conv_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .img_flat  (img_flat),
        .fil_flat  (fil_flat),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- DUT 5x5 / 3x3 ----------------
    logic               start5, busy5, valid5, ready5, done5;
    logic [199:0]       img5;
    logic [71:0]        fil5;
    logic signed [7:0]  data5;
    logic [1:0]         row5, col5;
    logic [1:0]         state5;

    systolic_conv_engine #(.IMG_N(5), .KER_K(3)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .start     (start5),
        .img_flat  (img5),
        .fil_flat  (fil5),
        .busy      (busy5),
        .out_valid (valid5),
        .out_ready (ready5),
        .out_data  (data5),
        .out_row   (row5),
        .out_col   (col5),
        .done      (done5),
        .fsm_state (state5)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] ramp16();
        logic [127:0] v;
        for (int e = 0; e < 16; e++) v[e*8 +: 8] = 8'(e + 1);
        return v;
    endfunction

    function automatic logic [199:0] ramp25();
        logic [199:0] v;
        for (int e = 0; e < 25; e++) v[e*8 +: 8] = 8'(e + 1);
        return v;
    endfunction

    function automatic logic [127:0] fill16(input logic [7:0] x);
        logic [127:0] v;
        for (int e = 0; e < 16; e++) v[e*8 +: 8] = x;
        return v;
    endfunction

    function automatic logic [71:0] fill9(input logic [7:0] x);
        logic [71:0] v;
        for (int e = 0; e < 9; e++) v[e*8 +: 8] = x;
        return v;
    endfunction

    task automatic push4(input int a, input int b, input int c, input int d);
        exp_q.push_back(8'(a));
        exp_q.push_back(8'(b));
        exp_q.push_back(8'(c));
        exp_q.push_back(8'(d));
    endtask

    // ---------------- driver: one job on the 4x4 DUT ----------------
    // Called at a negedge. stall_idx >= 0 holds out_ready low for 3 cycles
    // when that result is first presented. poke pulses start at COMPUTE
    // cycle 4 and again in FIN.
    task automatic run4(input logic [127:0] img, input logic [71:0] fil,
                        input int stall_idx, input int exp_done, input bit poke);
        int start_cyc, k, n, budget, stall_left, first_n;
        logic signed [7:0] e;
        img_flat  = img;
        fil_flat  = fil;
        start     = 1'b1;
        out_ready = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        img_flat = '1;
        fil_flat = '1;
        check("busy_go", busy, 1);
        k          = 0;
        budget     = 100;
        first_n    = -1;
        stall_left = (stall_idx >= 0) ? 3 : 0;
        while (k < 4 && budget > 0 && exp_q.size() > 0) begin
            n     = cyc - start_cyc;
            start = poke && (n == 4);
            if (out_valid) begin
                if (first_n < 0) first_n = n;
                e = exp_q[0];
                check("data", out_data, e);
                check("row", out_row, k / 2);
                check("col", out_col, k % 2);
                if (k == stall_idx && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    void'(exp_q.pop_front());
                    k++;
                end
            end
            @(negedge clk);
            budget--;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("results_seen", k, 4);
        check("first_valid_cyc", first_n, 10);
        n = cyc - start_cyc;
        check("done_pulse", done, 1);
        check("done_cyc", n, exp_done);
        check("valid_in_fin", out_valid, 0);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_once", done, 0);
        check("busy_idle", busy, 0);
    endtask

    // ---------------- driver: one job on the 5x5 DUT ----------------
    task automatic run5(input int exp_done);
        int start_cyc, k, budget, n;
        logic signed [7:0] e;
        img5      = ramp25();
        fil5      = fill9(8'd1);
        start5    = 1'b1;
        ready5    = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start5 = 1'b0;
        img5   = '0;
        fil5   = '0;
        k      = 0;
        budget = 100;
        while (k < 9 && budget > 0 && exp_q.size() > 0) begin
            if (valid5) begin
                e = exp_q.pop_front();
                check("n5_data", data5, e);
                check("n5_row", row5, k / 3);
                check("n5_col", col5, k % 3);
                k++;
            end
            @(negedge clk);
            budget--;
        end
        check("n5_results_seen", k, 9);
        n = cyc - start_cyc;
        check("n5_done", done5, 1);
        check("n5_done_cyc", n, exp_done);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        start     = 1'b0;
        out_ready = 1'b1;
        img_flat  = '0;
        fil_flat  = '0;
        start5    = 1'b0;
        ready5    = 1'b1;
        img5      = '0;
        fil5      = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        check("rst_done", done, 0);
        check("rst_state", fsm_state, 0);
        rst = 1'b1;
        @(negedge clk);

        // ramp image, unit filter
        push4(54, 63, 90, 99);
        run4(ramp16(), fill9(8'd1), -1, 14, 1'b0);

        // positive saturation
        push4(127, 127, 127, 127);
        run4(fill16(8'd127), fill9(8'd127), -1, 14, 1'b0);

        // negative saturation
`ifdef SYSTOLIC_CONV_RELU_EN
        push4(0, 0, 0, 0);
`else
        push4(-128, -128, -128, -128);
`endif
        run4(fill16(8'd127), fill9(8'h80), -1, 14, 1'b0);

        // negative results in range
`ifdef SYSTOLIC_CONV_RELU_EN
        push4(0, 0, 0, 0);
`else
        push4(-54, -63, -90, -99);
`endif
        run4(ramp16(), fill9(8'hFF), -1, 14, 1'b0);

        // backpressure on (0,1): done moves out by 3 cycles
        push4(54, 63, 90, 99);
        run4(ramp16(), fill9(8'd1), 1, 17, 1'b0);

        // start pulses while busy and in FIN are ignored
        push4(54, 63, 90, 99);
        run4(ramp16(), fill9(8'd1), -1, 14, 1'b1);

        // reset in the middle of COMPUTE aborts the job
        img_flat = ramp16();
        fil_flat = fill9(8'd1);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_state", fsm_state, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", done, 0);

        // fresh job after the abort
        push4(54, 63, 90, 99);
        run4(ramp16(), fill9(8'd1), -1, 14, 1'b0);

        // 5x5 image, 3x3 output grid with saturation on the last row
        exp_q.push_back(8'd63);
        exp_q.push_back(8'd72);
        exp_q.push_back(8'd81);
        exp_q.push_back(8'd108);
        exp_q.push_back(8'd117);
        exp_q.push_back(8'd126);
        exp_q.push_back(8'd127);
        exp_q.push_back(8'd127);
        exp_q.push_back(8'd127);
        run5(19);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/systolic_conv_engine.md
Name: systolic_conv_engine

Overview:
Parametrised successor to the fixed 4x4-image / 3x3-filter / 2x2-output systolic convolver. It computes a valid-mode 2-D convolution of an IMG_N x IMG_N signed image with a KER_K x KER_K signed filter on an OUT_N x OUT_N array of MAC PEs, where OUT_N = IMG_N-KER_K+1. It runs from a start/busy handshake and streams results row-major over a valid/ready output port. It sits between the image/filter buffer stage and the downstream pooling/writeback stage.

Parameters:
IMG_N, 4, image side length (>= KER_K)
KER_K, 3, filter side length (>= 1)
DATA_W, 8, signed width of image and filter elements
ACC_W, 2*DATA_W+clog2(KER_K*KER_K), signed PE accumulator width
OUT_W, 8, signed width of out_data after saturation

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-low (0 = reset)
start  in  1  request a convolution; sampled only in IDLE
img_flat  in  IMG_N*IMG_N*DATA_W  image, row-major, element (0,0) in LSBs
fil_flat  in  KER_K*KER_K*DATA_W  filter, row-major, element (0,0) in LSBs
busy  out  1  high in any state other than IDLE
out_valid  out  1  out_data/out_row/out_col hold a result
out_ready  in  1  downstream accepts the result when out_valid & out_ready
out_data  out  OUT_W  saturated convolution result
out_row  out  max(1,clog2(OUT_N))  row index of the current result
out_col  out  max(1,clog2(OUT_N))  column index of the current result
done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- One clock (clk). Reset is synchronous and active-low on rst. While rst=0 at a clock edge: state=IDLE, all accumulators and counters are 0, busy=0, out_valid=0, out_data=0, out_row=0, out_col=0, done=0.
- FSM states are IDLE, COMPUTE, STREAM and FIN.
- IDLE: on start=1, latch img_flat and fil_flat into internal registers, clear all accumulators, set tap counter t=0, and go to COMPUTE. Input buses are don't-care after the start edge.
- COMPUTE: lasts exactly KER_K*KER_K cycles. In tap t, r=t/KER_K and c=t%KER_K. Each PE(i,j) does acc += img[i+r][j+c] * fil[r][c] as a signed multiply, sign-extended to ACC_W. After t=KER_K*KER_K-1, go to STREAM.
- STREAM: present the results in row-major order. out_data = sat(acc(i,j)), clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_valid stays 1 throughout STREAM.
  - The index advances only on out_valid & out_ready.
  - While out_ready=0, out_data, out_row and out_col hold stable.
  - On the handshake of the last result (OUT_N-1, OUT_N-1), go to FIN.
- FIN: out_valid=0, done=1 for one cycle, then IDLE.
- Latency: with the start edge at cycle 0, the first out_valid is at cycle KER_K*KER_K+1. With out_ready tied high, done pulses at cycle KER_K*KER_K+OUT_N*OUT_N+1.
- Start is ignored whenever busy=1. Start in the FIN cycle is ignored; start is accepted from IDLE onward.
- rst=0 mid-COMPUTE or mid-STREAM aborts the operation immediately and gives the reset values. No done pulse is produced for the aborted job.
- Accumulators never overflow at the default ACC_W; saturation is applied only at the output.

Optional Feature:
Macro SYSTOLIC_CONV_RELU_EN.
- Defined: a negative saturated result is output as 0, with the ReLU applied after saturation.
- Undefined: signed saturated results pass unchanged.
- Handshake and timing are identical in both builds.

Decomposition:
- Package systolic_conv_pkg holds:
  - the FSM state enum (IDLE, COMPUTE, STREAM, FIN)
  - the function sat_fn(acc, OUT_W)
  - the function relu_fn
  - a localparam helper for OUT_N and index widths
- Sub-module systolic_conv_pe: a signed MAC with synchronous active-low clear, clear-on-start, and enable during COMPUTE. It is instantiated OUT_N*OUT_N times with a generate loop.
- Pixel selection (img[i+r][j+c]) and the output mux stay in the top level.

Test Plan:
1. Defaults, image 1..16 row-major, filter all 1, out_ready=1: results 54, 63, 90, 99 at (0,0), (0,1), (1,0), (1,1); first out_valid at cycle 10; done at cycle 14.
2. Image all 127, filter all 127: acc = 145161, out_data = 127 for all four results. Image all 127, filter all -128: out_data = -128 without RELU_EN, 0 with it.
3. Filter all -1, image 1..16: out_data -54, -63, -90, -99 without SYSTOLIC_CONV_RELU_EN; 0, 0, 0, 0 with it.
4. Backpressure: drop out_ready for 3 cycles while (0,1) is presented. out_data holds 63 and out_col holds 1, there is no skip or duplicate, and done is delayed by 3 cycles.
5. Pulse start at cycle 4 of COMPUTE and again in FIN: both are ignored and results are unchanged. Assert rst=0 during COMPUTE: next cycle busy=0, out_valid=0; a fresh start yields correct results.
6. IMG_N=5, KER_K=3, image 1..25, filter all 1: 9 results 63, 72, 81, 108, 117, 126, 153→127 (sat), 162→127, 171→127.
